fircoe_rd_burst: RTL and testbench

- DDR read-burst engine; reads FIR tap coefficients back from the DDR region filled by the coefficient write path.
- Issues fixed-length read bursts to the DDR user-port arbiter and buffers the returned 512-bit words.
- Unpacks each word into a 32-bit coefficient stream with valid/ready handshake; everything runs in ddr_clk.

---
 rtl/fircoe_rd_burst_if.sv | 32 +++
 rtl/fircoe_rd_burst.sv | 204 ++++++++++++++++++++
 tb/tb_fircoe_rd_burst.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fircoe_rd_burst_if.sv
// DDR read-burst port and coefficient stream of the FIR coefficient reader.
// The reader drives the master side; the DDR arbiter and coefficient consumer sit on the slave side.
interface fircoe_rd_burst_if #(
   parameter int DDR_ADDR_WD = 32,
   parameter int DDR_DATA_WD = 512,
   parameter int RD_DATA_WD  = 32
);
   logic                   rd_burst_req;
   logic [9:0]             rd_burst_len;
   logic [DDR_ADDR_WD-1:0] rd_burst_addr;
   logic                   rd_burst_data_valid;
   logic [DDR_DATA_WD-1:0] rd_burst_data;
   logic                   rd_burst_finish;
   logic                   coe_vld;
   logic [RD_DATA_WD-1:0]  coe_data;
   logic                   coe_last;
   logic                   coe_ready;

   modport master (
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      output coe_vld, coe_data, coe_last,
      input  coe_ready
   );

   modport slave (
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      input  coe_vld, coe_data, coe_last,
      output coe_ready
   );
endinterface

// File: rtl/fircoe_rd_burst.sv
// DDR read-burst engine: fetches FIR coefficients in fixed bursts, buffers DDR words, unpacks MSB lane first.
// Optional watchdog enabled by defining RD_TIMEOUT_EN.
module fircoe_rd_burst #(
   parameter int                     FIFO_DEPTH   = 32,
   parameter int                     RD_DATA_WD   = 32,
   parameter int                     DDR_ADDR_WD  = 32,
   parameter int                     DDR_DATA_WD  = 512,
   parameter int                     BURST_LEN    = 8,
   parameter logic [DDR_ADDR_WD-1:0] BASE_ADDR    = 32'h00000,
   parameter logic [31:0]            MAX_BLK_SIZE = 32'h20000,
   parameter logic [15:0]            TIMEOUT      = 16'd5000
) (
   input  logic                   ddr_clk,
   input  logic                   ddr_rst_n,
   input  logic                   cfg_rst,
   input  logic                   load_start,
   input  logic [DDR_ADDR_WD-1:0] load_blk,
   input  logic [31:0]            load_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   fircoe_rd_burst_if.master      bus
);
   localparam int RATE   = DDR_DATA_WD / RD_DATA_WD;
   localparam int LANE_W = $clog2(RATE);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0]       CREDIT_MAX = CNT_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [DDR_ADDR_WD-1:0] BLK_MASK   = DDR_ADDR_WD'(MAX_BLK_SIZE - 32'd1);

   typedef enum logic [2:0] {IDLE, CHK, REQ, RECV, WAIT_OUT, DRAIN} state_t;

   typedef struct packed {
      logic [DDR_ADDR_WD-1:0] blk;
      logic [31:0]            len;
      logic [31:0]            need;
   } load_t;

   state_t                 state, state_nxt;
   load_t                  ld;
   logic [1:0]             cfg_sync;
   logic                   clr, flush, wd_hit, in_burst, start, fin, wr_en, pop;
   logic                   hs, last_beat, last_hs, all_out, done_nxt, done_set;
   logic [32:0]            need_sum;
   logic [31:0]            need_w, words_req, words_wr, beats;
   logic [DDR_ADDR_WD-1:0] blk_cnt, blk_off;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt;
   logic [DDR_DATA_WD-1:0] mem [FIFO_DEPTH];
   logic [RATE-1:0][RD_DATA_WD-1:0] up_word;
   logic [LANE_W-1:0]      lane;
   logic                   up_vld;

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n) cfg_sync <= '0;
      else            cfg_sync <= {cfg_sync[0], cfg_rst};

   assign clr       = cfg_sync[1];
   assign flush     = clr | wd_hit;
   assign in_burst  = (state == REQ) || (state == RECV);
   assign start     = (state == IDLE) && load_start && (load_len != 32'd0) && !clr;
   assign fin       = in_burst && bus.rd_burst_finish;
   // Words past the load's need are dropped so the buffer never holds stale data for the next load.
   assign wr_en     = in_burst && bus.rd_burst_data_valid && (words_wr < ld.need) && !flush;
   assign hs        = up_vld && bus.coe_ready;
   assign last_beat = (beats == ld.len - 32'd1);
   assign last_hs   = hs && last_beat;
   assign pop       = (fifo_cnt != '0) && !all_out &&
                      (!up_vld || (hs && (lane == '0) && !last_beat));

   assign need_sum = {1'b0, load_len} + 33'(RATE - 1);
   assign need_w   = 32'(need_sum >> LANE_W);

   assign blk_off           = (ld.blk + blk_cnt) & BLK_MASK;
   assign bus.rd_burst_addr = BASE_ADDR + (blk_off << 3);
   assign bus.rd_burst_len  = 10'(BURST_LEN);
   assign bus.rd_burst_req  = (state == REQ);
   assign busy              = (state != IDLE);

`ifdef RD_TIMEOUT_EN
   logic [15:0] wd_cnt;
   logic        err_q;

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n)                   wd_cnt <= '0;
      else if (!in_burst || fin || clr) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 16'd1;

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n)  err_q <= 1'b0;
      else if (clr)    err_q <= 1'b0;
      else if (wd_hit) err_q <= 1'b1;

   assign wd_hit = in_burst && (wd_cnt == TIMEOUT) && !clr;
   assign err    = err_q;
`else
   assign wd_hit = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n) state <= IDLE;
      else            state <= state_nxt;

   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = CHK;
         // Credit check: a burst is only requested when it is guaranteed to fit.
         CHK:      if (words_req >= ld.need)   state_nxt = WAIT_OUT;
                   else if (fifo_cnt <= CREDIT_MAX) state_nxt = REQ;
         REQ:      if (fin) state_nxt = CHK;
                   else if (bus.rd_burst_data_valid) state_nxt = RECV;
         RECV:     if (fin) state_nxt = CHK;
         WAIT_OUT: if (last_hs || all_out) begin
                      state_nxt = IDLE;
                      done_set  = 1'b1;
                   end
         DRAIN:    if (bus.rd_burst_finish) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (wd_hit) begin
         state_nxt = IDLE;
         done_set  = 1'b0;
      end
      if (clr) begin
         state_nxt = (in_burst || (state == DRAIN && !bus.rd_burst_finish)) ? DRAIN : IDLE;
         done_set  = 1'b0;
      end
   end

   assign done_nxt = done_set ||
                     ((state == IDLE) && load_start && (load_len == 32'd0) && !clr);

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n) begin
         ld        <= '0;
         words_req <= '0;
         words_wr  <= '0;
         blk_cnt   <= '0;
         beats     <= '0;
         all_out   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= done_nxt;
         if (flush || start) begin
            words_req <= '0;
            words_wr  <= '0;
            blk_cnt   <= '0;
            beats     <= '0;
            all_out   <= 1'b0;
            if (start) ld <= '{blk: load_blk, len: load_len, need: need_w};
         end else begin
            if (wr_en) words_wr <= words_wr + 32'd1;
            if (fin) begin
               words_req <= words_req + 32'(BURST_LEN);
               blk_cnt   <= blk_cnt + DDR_ADDR_WD'(BURST_LEN);
            end
            if (hs)      beats   <= beats + 32'd1;
            if (last_hs) all_out <= 1'b1;
         end
      end

   // Word buffer; FIFO_DEPTH is a power of two so the pointers wrap naturally.
   always_ff @(posedge ddr_clk)
      if (wr_en) mem[wr_ptr] <= bus.rd_burst_data;

   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + CNT_W'(wr_en) - CNT_W'(pop);
      end

   // Unpacker: lane RATE-1 goes out first, undoing the write path's lane reversal.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n)
      if (!ddr_rst_n) begin
         up_vld  <= 1'b0;
         lane    <= '0;
         up_word <= '0;
      end else if (flush) begin
         up_vld <= 1'b0;
      end else if (pop) begin
         up_word <= mem[rd_ptr];
         lane    <= LANE_W'(RATE - 1);
         up_vld  <= 1'b1;
      end else if (hs) begin
         if (last_beat || lane == '0) up_vld <= 1'b0;
         else                         lane   <= lane - 1'b1;
      end

   assign bus.coe_vld  = up_vld;
   assign bus.coe_data = up_word[lane];
   assign bus.coe_last = up_vld && last_beat;
endmodule

// File: tb/tb_fircoe_rd_burst.sv
// Randomized scoreboard bench for fircoe_rd_burst with a DDR burst responder and a lane-level reference model.
module tb_fircoe_rd_burst;
  localparam int          RATE = 16;
  localparam int          BL   = 8;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] MAXB = 32'h20000;
  localparam logic [31:0] MASK = MAXB - 32'd1;
  localparam int          TMO  = 5000;

  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  logic        ddr_clk = 1'b0, ddr_rst_n = 1'b0, cfg_rst = 1'b0, load_start = 1'b0;
  logic [31:0] load_blk = '0, load_len = '0;
  logic        busy, done, err;

  fircoe_rd_burst_if bus();

  fircoe_rd_burst dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .cfg_rst(cfg_rst),
    .load_start(load_start), .load_blk(load_blk), .load_len(load_len),
    .busy(busy), .done(done), .err(err), .bus(bus.master)
  );

  always #5 ddr_clk = ~ddr_clk;

  int    n_vec = 0, n_fail = 0, cyc = 0;
  beat_t exp_q[$];
  logic [31:0] addr_q[$];
  int    rsp_mode = 0, rdy_mode = 0, words_sent = 0, req_cyc = 0;
  logic  rsp_active = 1'b0;
  int    done_cnt = 0, done_cyc = 0, last_cyc = 0;

  always @(posedge ddr_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // DDR content: every lane of every word address is distinct.
  function automatic logic [31:0] lane_val(input logic [31:0] wa, input int l);
    return (wa * 32'h9E3779B1) ^ (32'(l) * 32'h01000193) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [511:0] mk_word(input logic [31:0] wa);
    logic [511:0] w;
    for (int l = 0; l < RATE; l++) w[l*32 +: 32] = lane_val(wa, l);
    return w;
  endfunction

  // Reference: beat i comes from load word i/16, lane 15-(i%16); word w lives in burst w/8 at masked base + w%8.
  task automatic push_exp(input logic [31:0] blk, input int len);
    int need, nb;
    need = (len + RATE - 1) / RATE;
    nb   = (need + BL - 1) / BL;
    for (int i = 0; i < len; i++) begin
      int w;
      logic [31:0] wa;
      beat_t b;
      w    = i / RATE;
      wa   = ((blk + 32'((w / BL) * BL)) & MASK) + 32'(w % BL);
      b.d  = lane_val(wa, RATE - 1 - (i % RATE));
      b.l  = (i == len - 1);
      exp_q.push_back(b);
    end
    for (int k = 0; k < nb; k++) addr_q.push_back(BASE + (((blk + 32'(k * BL)) & MASK) << 3));
  endtask

  task automatic pulse_start(input logic [31:0] blk, input logic [31:0] len, output int sc);
    @(posedge ddr_clk); #1;
    sc = cyc;
    load_start = 1'b1; load_blk = blk; load_len = len;
    @(posedge ddr_clk); #1;
    load_start = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] blk, input int len, input int rmode, input bit strict);
    int d0, t, sc;
    rdy_mode = rmode;
    push_exp(blk, len);
    d0 = done_cnt;
    pulse_start(blk, 32'(len), sc);
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(posedge ddr_clk); t++; end
    #1;
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("beats_left", 64'(exp_q.size()), 0);
    chk("bursts_left", 64'(addr_q.size()), 0);
    if (len == 0)    chk("done_len0_cycle", 64'(done_cyc), 64'(sc + 1));
    else if (strict) chk("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    else             chk("done_not_early", done_cyc > last_cyc, 1);
    exp_q.delete(); addr_q.delete();
  endtask

  // DDR responder: answers each request with BL words, random gaps, finish with or after the last word.
  initial begin
    logic [31:0] wa0;
    int gap;
    bit same;
    bus.rd_burst_data_valid = 1'b0; bus.rd_burst_finish = 1'b0; bus.rd_burst_data = '0;
    forever begin
      @(posedge ddr_clk); #1;
      if (bus.rd_burst_req) begin
        rsp_active = 1'b1;
        req_cyc = cyc;
        if (addr_q.size() == 0) chk("burst_unexpected", bus.rd_burst_addr, 64'hFFFF_FFFF_FFFF);
        else                    chk("burst_addr", bus.rd_burst_addr, addr_q.pop_front());
        chk("burst_len", bus.rd_burst_len, BL);
        wa0  = (bus.rd_burst_addr - BASE) >> 3;
        same = $urandom_range(0, 1) == 1;
        for (int j = 0; j < BL; j++) begin
          if (rsp_mode == 2 && j >= 2) break;
          gap = (rsp_mode == 1 && j >= 3) ? 4 : $urandom_range(0, 2);
          repeat (gap) begin @(posedge ddr_clk); #1; end
          bus.rd_burst_data_valid = 1'b1;
          bus.rd_burst_data = mk_word(wa0 + 32'(j));
          bus.rd_burst_finish = (j == BL - 1) && same && rsp_mode != 2;
          @(posedge ddr_clk); #1;
          bus.rd_burst_data_valid = 1'b0; bus.rd_burst_finish = 1'b0;
          words_sent++;
        end
        if (!same && rsp_mode != 2) begin
          repeat ($urandom_range(0, 2)) begin @(posedge ddr_clk); #1; end
          bus.rd_burst_finish = 1'b1;
          @(posedge ddr_clk); #1;
          bus.rd_burst_finish = 1'b0;
        end
        rsp_active = 1'b0;
      end
    end
  end

  initial begin
    bus.coe_ready = 1'b0;
    forever begin
      @(posedge ddr_clk); #1;
      bus.coe_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 40);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat; checks hold-under-backpressure.
  initial begin
    beat_t e;
    logic prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0; prev_data = '0;
    forever begin
      @(negedge ddr_clk);
      if (!ddr_rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("hold_vld", bus.coe_vld, 1);
          chk("hold_data", bus.coe_data, prev_data);
        end
        if (bus.coe_vld && bus.coe_ready) begin
          if (exp_q.size() == 0) chk("beat_unexpected", bus.coe_data, 64'hFFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("coe_data", bus.coe_data, e.d);
            chk("coe_last", bus.coe_last, e.l);
            if (e.l) last_cyc = cyc;
          end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        prev_stall = bus.coe_vld && !bus.coe_ready;
        prev_data  = bus.coe_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t, d0, sc;
    repeat (3) @(posedge ddr_clk);
    #1;
    chk("rst_req", bus.rd_burst_req, 0);
    chk("rst_vld", bus.coe_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    ddr_rst_n = 1'b1;
    @(posedge ddr_clk); #1;
    chk("idle_last", bus.coe_last, 0);
    chk("idle_addr", bus.rd_burst_addr, BASE);

    run_load(32'd0, 256, 0, 1'b1);
    run_load(32'd0, 20, 0, 1'b0);
    run_load(MAXB - 32'd8, 256, 0, 1'b1);
    run_load(32'd0, 0, 0, 1'b0);
    run_load(32'h100, 1024, 1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_load($urandom & MASK, $urandom_range(1, 400), 1, 1'b0);

    // cfg_rst while receiving the third word of a burst.
    rdy_mode = 0; rsp_mode = 1; words_sent = 0;
    d0 = done_cnt;
    push_exp(32'h40, 256);
    pulse_start(32'h40, 32'd256, sc);
    t = 0;
    while (words_sent < 3 && t < 500) begin @(posedge ddr_clk); #1; t++; end
    chk("abort_words_seen", words_sent >= 3, 1);
    cfg_rst = 1'b1;
    repeat (3) begin @(posedge ddr_clk); #1; end
    cfg_rst = 1'b0;
    chk("abort_req_low", bus.rd_burst_req, 0);
    t = 0;
    while (rsp_active && t < 500) begin @(posedge ddr_clk); #1; t++; end
    repeat (2) begin @(posedge ddr_clk); #1; end
    chk("abort_idle", busy, 0);
    chk("abort_vld", bus.coe_vld, 0);
    chk("abort_req", bus.rd_burst_req, 0);
    chk("abort_no_done", 64'(done_cnt - d0), 0);
    exp_q.delete(); addr_q.delete(); rsp_mode = 0;
    run_load(32'h18, 100, 1, 1'b0);

`ifdef RD_TIMEOUT_EN
    rsp_mode = 2; rdy_mode = 0;
    d0 = done_cnt;
    push_exp(32'd0, 256);
    pulse_start(32'd0, 32'd256, sc);
    t = 0;
    while (!err && t < TMO + 300) begin @(posedge ddr_clk); #1; t++; end
    chk("wd_err", err, 1);
    chk("wd_latency_ok", (cyc - req_cyc >= TMO) && (cyc - req_cyc <= TMO + 2), 1);
    @(posedge ddr_clk); #1;
    chk("wd_idle", busy, 0);
    chk("wd_req", bus.rd_burst_req, 0);
    chk("wd_no_done", 64'(done_cnt - d0), 0);
    cfg_rst = 1'b1;
    repeat (3) begin @(posedge ddr_clk); #1; end
    cfg_rst = 1'b0;
    chk("wd_err_cleared", err, 0);
    exp_q.delete(); addr_q.delete(); rsp_mode = 0;
    run_load(32'h8, 64, 1, 1'b0);
`else
    chk("err_tied_low", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
